seq_subtractor64: RTL
=====================

Name: seq_subtractor64

Overview:
- Multi-cycle 64-bit subtractor for the ALU datapath: diff = a - b - bin.
- Processes one SLICE_W-bit slice per clock, least-significant slice first, carrying the borrow between slices in a register. This trades latency for a short critical path.
- Reports borrow-out, zero and signed-overflow flags.
- Uses a start/busy/done handshake so the ALU control FSM can sequence it next to the single-cycle adder path.

Parameters:
- SLICE_W, 16, slice width in bits processed per cycle; must divide 64 (legal: 8, 16, 32, 64).
- NUM_SLICES, 64/SLICE_W, derived value (not overridden); this is the latency in cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- a  input  64  minuend; sampled on the accepting edge.
- b  input  64  subtrahend; sampled on the accepting edge.
- bin  input  1  borrow-in; sampled on the accepting edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; results valid.
- diff  output  64  result a - b - bin, mod 2^64.
- bout  output  1  borrow-out: 1 if a < b + bin (unsigned).
- zero  output  1  1 if diff == 0.
- ovf  output  1  signed overflow: (a[63]!=b[63]) && (diff[63]!=a[63]).

Behaviour:
- Reset (asynchronous, active-high, applied at any time including mid-operation):
  - busy=0, done=0, diff=0, bout=0, zero=0, ovf=0.
  - FSM goes to IDLE; slice counter=0.
  - Operand, accumulator and borrow registers cleared.
  - The operation in flight is discarded and no done is produced.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on a rising edge with start=1. That edge latches a, b, bin, clears the slice counter and sets busy=1.
  - RUN: each edge computes slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W) as a_k + ~b_k + ~borrow_reg, i.e. a_k - b_k - borrow_reg. The slice result goes into the internal accumulator; borrow_reg gets that slice's borrow-out.
  - At the first RUN edge, borrow_reg holds the latched bin.
  - RUN -> IDLE on the edge that computes slice NUM_SLICES-1. That same edge:
    - writes diff, bout, zero and ovf from the completed accumulator;
    - sets done=1 for exactly the following cycle;
    - sets busy=0.
- Latency: start accepted at edge E0; done=1 and results valid in the cycle after edge E0+NUM_SLICES (4 cycles at the default). Throughput is one operation per NUM_SLICES cycles.
- Output holding: diff and the flags change only on completion edges (and reset). Partial slice results are never visible on the outputs. Values hold until the next completion.
- done is registered; it deasserts one cycle after it asserts unless another completion occurs.
- start while busy=1 is ignored: no effect on operands or timing.
- start in the done cycle (busy=0) is accepted. This allows back-to-back operations with no idle gap.
- Operand inputs are don't-care except on the accepting edge. Changes mid-operation must not affect the result.
- Width rules:
  - Internal slice arithmetic is SLICE_W+1 bits; the MSB is the inverted borrow.
  - diff wraps mod 2^64.
  - ovf is computed from the latched a[63], b[63] and the final diff[63]; equivalently, carry into bit 63 xor carry out of bit 63.
- SLICE_W=64: single-cycle operation (NUM_SLICES=1); done follows the accepting edge by one cycle.

Test Plan:
- Reset, then a=0x0000_0000_0001_0000, b=0x1, bin=0, start -> done exactly 4 cycles after the accept edge. diff=0x0000_0000_0000_FFFF, bout=0, zero=0, ovf=0; the borrow crosses a slice boundary.
- a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0, zero=0. Then a=0x8000_0000_0000_0000, b=0, bin=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
- a=b=0x1234_5678_9ABC_DEF0, bin=0 -> diff=0, zero=1, bout=0. Then a=5, b=5, bin=1 -> diff=all ones, bout=1, zero=0.
- Start accepted; pulse start again and change a/b at cycles +1 and +2 -> single done with the original result. busy stays high for 4 cycles and diff is unchanged until done.
- Back-to-back: assert start again in the done cycle -> second done 4 cycles later. No lost or duplicated done; diff holds the first result until the second completion.
- Assert rst asynchronously at cycle +2 of an operation -> outputs immediately 0, no done pulse. After release, a new start (a=10, b=3) -> diff=7 with normal latency.

Source files
------------

// File: rtl/seq_subtractor64.sv
`default_nettype none
// ============================================================================
// Module      : seq_subtractor64
// Description : Multi-cycle 64-bit subtractor, diff = a - b - bin, one
//               SLICE_W-bit slice per clock with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_subtractor64 #(
   parameter int SLICE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [63:0] diff,
   output logic        bout,
   output logic        zero,
   output logic        ovf
);

   localparam int NUM_SLICES = 64 / SLICE_W;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] c_last_slice = CNT_W'(NUM_SLICES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [63:0]        r_a;
   logic [63:0]        r_b;
   logic               r_borrow;
   logic [63:0]        r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [63:0]        r_diff;
   logic               r_bout;
   logic               r_zero;
   logic               r_ovf;
   logic               r_done;

   logic [SLICE_W-1:0] w_a_k;
   logic [SLICE_W-1:0] w_b_k;
   logic [SLICE_W:0]   w_sum;
   logic [63:0]        w_acc_nxt;
   logic               w_last;

   // Slice result MSB is the carry of a + ~b + ~borrow, i.e. the inverted borrow.
   always_comb begin
      w_a_k     = r_a[r_cnt*SLICE_W +: SLICE_W];
      w_b_k     = r_b[r_cnt*SLICE_W +: SLICE_W];
      w_sum     = {1'b0, w_a_k} + {1'b0, ~w_b_k} + {{SLICE_W{1'b0}}, ~r_borrow};
      w_acc_nxt = r_acc;
      w_acc_nxt[r_cnt*SLICE_W +: SLICE_W] = w_sum[SLICE_W-1:0];
      w_last    = (r_cnt == c_last_slice);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_borrow <= bin;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_nxt;
               r_borrow <= ~w_sum[SLICE_W];
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  // Outputs only move here, so partial slices never leak out.
                  r_diff <= w_acc_nxt;
                  r_bout <= ~w_sum[SLICE_W];
                  r_zero <= (w_acc_nxt == 64'd0);
                  r_ovf  <= (r_a[63] != r_b[63]) && (w_acc_nxt[63] != r_a[63]);
                  r_done <= 1'b1;
                  r_cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;
   assign zero = r_zero;
   assign ovf  = r_ovf;

endmodule
`default_nettype wire
